// File: rtl/sterowanie_przesuniecia.sv
// Serial arithmetic right shift of i_arg_A by n = ~i_arg_B bits, one bit per cycle.
// Negative, zero and oversized shift amounts are resolved on the accepting edge without iterating.
module sterowanie_przesuniecia #(
  parameter int BITS  = 32,
  parameter int CNT_W = $clog2(BITS) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic signed [BITS-1:0] i_arg_A,
  input  logic signed [BITS-1:0] i_arg_B,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic signed [BITS-1:0] o_result,
  output logic                   o_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [BITS-1:0] MAX_SHIFT = BITS'(BITS - 1);

  state_t                   state_reg,  state_next;
  logic signed [BITS-1:0]   work_reg,   work_next;
  logic        [CNT_W-1:0]  count_reg,  count_next;
  logic                     error_reg,  error_next;
  logic signed [BITS-1:0]   shift_amt;

  // ~B equals -B-1, so the shift amount needs no adder.
  assign shift_amt = ~i_arg_B;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    count_next = count_reg;
    error_next = error_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          error_next = 1'b0;
          if (shift_amt < 0) begin
            work_next  = '0;
            error_next = 1'b1;
            state_next = DONE;
          end else if (shift_amt == 0) begin
            work_next  = i_arg_A;
            state_next = DONE;
          end else if ($unsigned(shift_amt) > MAX_SHIFT) begin
            // Every bit would be shifted out: only the sign survives.
            work_next  = {BITS{i_arg_A[BITS-1]}};
            state_next = DONE;
          end else begin
            work_next  = i_arg_A;
            count_next = shift_amt[CNT_W-1:0];
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_next  = {work_reg[BITS-1], work_reg[BITS-1:1]};
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_ready  = (state_reg == IDLE);
  assign o_busy   = (state_reg == SHIFT);
  assign o_valid  = (state_reg == DONE);
  assign o_result = work_reg;
  assign o_error  = error_reg;

endmodule

// File: tb/tb_sterowanie_przesuniecia.sv
// Directed and randomized checks of the serial shifter against an arithmetic reference model.
module tb_sterowanie_przesuniecia;

  localparam int BITS = 32;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic                   i_start;
  logic signed [BITS-1:0] i_arg_A;
  logic signed [BITS-1:0] i_arg_B;
  logic                   o_ready;
  logic                   o_busy;
  logic                   o_valid;
  logic signed [BITS-1:0] o_result;
  logic                   o_error;

  int checks = 0;
  int errors = 0;

  sterowanie_przesuniecia #(.BITS(BITS)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_error  (o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result is floor(A / 2^n), saturating to the sign for n >= BITS.
  function automatic void model(input logic signed [BITS-1:0] a, input logic signed [BITS-1:0] b,
                                output logic [BITS-1:0] res, output logic err, output int lat);
    logic signed [BITS-1:0] n;
    n   = -b - 1;
    err = 1'b0;
    lat = 0;
    if (n < 0) begin
      res = '0;
      err = 1'b1;
    end else if (n == 0) begin
      res = a;
    end else if (n >= BITS) begin
      res = (a < 0) ? '1 : '0;
    end else begin
      res = a >>> n;
      lat = int'(n);
    end
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Starts one operation and checks latency, busy time, result and hold behaviour.
  // inj >= 0 pulses i_start with other arguments that many cycles after acceptance.
  task automatic run_op(input logic signed [BITS-1:0] a, input logic signed [BITS-1:0] b, input int inj);
    logic [BITS-1:0] exp_res;
    logic            exp_err;
    int              exp_lat;
    int              lat;
    int              busy_cnt;
    int              k;
    model(a, b, exp_res, exp_err, exp_lat);
    k = 0;
    while (!o_ready && k < 100) begin
      tick();
      k++;
    end
    check("ready_before_start", {31'b0, o_ready}, 1);
    i_start = 1'b1;
    i_arg_A = a;
    i_arg_B = b;
    tick();
    i_start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!o_valid && lat < BITS + 5) begin
      if (o_busy) busy_cnt++;
      if (lat == inj) begin
        i_start = 1'b1;
        i_arg_A = 5;
        i_arg_B = -3;
      end else if (lat == inj + 1) begin
        i_start = 1'b0;
      end
      tick();
      lat++;
    end
    i_start = 1'b0;
    check("valid", {31'b0, o_valid}, 1);
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("result", o_result, exp_res);
    check("error", {31'b0, o_error}, {31'b0, exp_err});
    $display("op A=%h B=%h result=%h err=%b lat=%0d", a, b, o_result, o_error, lat);
    tick();
    check("valid_one_cycle", {31'b0, o_valid}, 0);
    check("ready_after_done", {31'b0, o_ready}, 1);
    check("result_held", o_result, exp_res);
    check("error_held", {31'b0, o_error}, {31'b0, exp_err});
  endtask

  initial begin
    logic signed [BITS-1:0] ra;
    logic signed [BITS-1:0] rb;
    logic        [BITS-1:0] nn;
    int                     r;
    int                     seen;
    int                     pulses[$];
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_arg_A = 32'h1234_5678;
    i_arg_B = -3;
    tick();
    tick();
    i_rst   = 1'b0;
    i_start = 1'b0;
    check("rst_ready", {31'b0, o_ready}, 1);
    check("rst_busy",  {31'b0, o_busy}, 0);
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_result", o_result, 0);
    check("rst_error", {31'b0, o_error}, 0);

    // Directed cases.
    run_op(32'h8000_0000, -5, -1);
    run_op(32'h0000_00F0, -5, -1);
    run_op(32'h1234_5678, -1, -1);
    run_op(-7, -33, -1);
    run_op(7, 32'h8000_0000, -1);
    run_op(100, 0, -1);
    run_op(100, -2, -1);
    run_op(-1, -32, 3);

    // Reset in the middle of a 20-bit shift.
    i_start = 1'b1;
    i_arg_A = 32'hDEAD_BEEF;
    i_arg_B = -21;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("busy_before_abort", {31'b0, o_busy}, 1);
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    check("abort_ready", {31'b0, o_ready}, 1);
    check("abort_busy", {31'b0, o_busy}, 0);
    check("abort_result", o_result, 0);
    check("abort_error", {31'b0, o_error}, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_valid) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    $display("op reset-abort valid_pulses=%0d", seen);

    // i_start held high: pulses spaced n+2 cycles apart.
    i_start = 1'b1;
    i_arg_A = 32'h0000_0800;
    i_arg_B = -4;
    for (int i = 0; i < 100 && pulses.size() < 3; i++) begin
      tick();
      if (o_valid) begin
        pulses.push_back(i);
        check("held_result", o_result, 32'h0000_0100);
      end
    end
    i_start = 1'b0;
    check("held_pulse_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check("held_spacing_1", pulses[1] - pulses[0], 5);
      check("held_spacing_2", pulses[2] - pulses[1], 5);
      $display("op held-start pulses at %0d %0d %0d", pulses[0], pulses[1], pulses[2]);
    end
    tick();
    tick();

    // Randomized operations spread over all shift-amount classes.
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 6) begin
        nn = $urandom_range(0, BITS - 1);
        rb = ~nn;
      end else if (r < 8) begin
        rb = $urandom;
      end else begin
        nn = $urandom_range(BITS, 200);
        rb = ~nn;
      end
      run_op(ra, rb, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
